// File: rtl/axioma_pkg.sv
// axioma_pkg: shared reset-controller constants (FSM encodings, MCUSR bit indices, start-up cycle counts).
package axioma_pkg;
  localparam logic [1:0] HOLD = 2'd0, DELAY = 2'd1, RUN = 2'd2;
  localparam int PORF = 0, EXTRF = 1, BORF = 2, WDRF = 3;
  localparam int SUT_SHORT = 8, SUT_4MS = 512, SUT_64MS = 8192;
  function automatic int unsigned sut_cycles(input logic [1:0] sel);
    return sel == 2'b00 ? SUT_SHORT : sel == 2'b01 ? SUT_4MS : SUT_64MS;
  endfunction
endpackage

// File: rtl/axioma_sync_bit.sv
// axioma_sync_bit: multi-flop synchronizer for one asynchronous bit, with a selectable reset level.
module axioma_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_128khz,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk_128khz or negedge reset_n)
    if (!reset_n) ff <= {STAGES{RST_VAL}};
    else ff <= (ff << 1) | STAGES'(d);
  assign q = ff[STAGES-1];
endmodule

// File: rtl/axioma_reset_ctrl.sv
// axioma_reset_ctrl: stretched system reset and MCUSR cause flags on the 128 kHz watchdog clock.
// Optional RESET-pin glitch filter enabled by defining AXIOMA_RST_GLITCH_FILTER_EN.
module axioma_reset_ctrl
  import axioma_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYC  = 4,
  parameter int CNT_W       = 14
) (
  input  logic       clk_128khz,
  input  logic       reset_n,
  input  logic       ext_reset_n,
  input  logic       bod_reset,
  input  logic       wdt_reset,
  input  logic [1:0] sut_sel,
  input  logic [3:0] mcusr_clr,
  output logic       sys_reset_n,
  output logic [3:0] mcusr_flags,
  output logic [1:0] rst_state
);
  logic ext_s, bod_s, wdt_s, ext_act, src_any;
  logic [3:0] clr_s, set;
  logic [1:0] state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt, n_last;

  axioma_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ext (.clk_128khz, .reset_n, .d(ext_reset_n), .q(ext_s));
  axioma_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_bod (.clk_128khz, .reset_n, .d(bod_reset), .q(bod_s));
  axioma_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_wdt (.clk_128khz, .reset_n, .d(wdt_reset), .q(wdt_s));
  for (genvar i = 0; i < 4; i++) begin : g_clr
    axioma_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clr (.clk_128khz, .reset_n, .d(mcusr_clr[i]), .q(clr_s[i]));
  end

`ifdef AXIOMA_RST_GLITCH_FILTER_EN
  // count saturates at FILTER_CYC; a high sample drops ext_act in the same cycle
  logic [3:0] flt_cnt;
  always_ff @(posedge clk_128khz or negedge reset_n)
    if (!reset_n) flt_cnt <= '0;
    else if (ext_s) flt_cnt <= '0;
    else if (flt_cnt != 4'(FILTER_CYC)) flt_cnt <= flt_cnt + 4'd1;
  assign ext_act = !ext_s && flt_cnt == 4'(FILTER_CYC);
`else
  assign ext_act = !ext_s;
`endif

  assign src_any = ext_act | bod_s | wdt_s;
  assign n_last  = CNT_W'(sut_cycles(sut_sel) - 1);
  assign set     = {wdt_s, bod_s, ext_act, 1'b0};

  always_comb begin
    next_state = HOLD;
    next_cnt   = '0;
    case (state)
      HOLD:  next_state = src_any ? HOLD : DELAY;
      DELAY: begin
        next_state = src_any ? HOLD : cnt >= n_last ? RUN : DELAY;
        next_cnt   = src_any ? '0 : cnt >= n_last ? cnt : cnt + 1'b1;
      end
      RUN:   next_state = src_any ? HOLD : RUN;
      default: next_state = HOLD;
    endcase
  end

  // any active source forces HOLD, so setting on every active source covers all HOLD entries
  always_ff @(posedge clk_128khz or negedge reset_n)
    if (!reset_n) begin
      state       <= HOLD;
      cnt         <= '0;
      sys_reset_n <= 1'b0;
      mcusr_flags <= 4'b0001;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      sys_reset_n <= next_state == RUN;
      mcusr_flags <= (mcusr_flags & ~clr_s) | set;
    end

  assign rst_state = state;
endmodule
